// File: rtl/ins_fetch_if.sv
// ins_fetch_if
// Bundles every signal between the fetch unit and its surroundings:
// the program counter, the instruction ROM and the execute datapath.
//   start       : begin execution (environment -> fetch)
//   ins_address : current PC value (PC -> fetch)
//   rom_data    : ROM word {opcode, operand}, valid the cycle after rom_en
//   z_flag      : datapath zero flag, consulted by conditional jumps
//   ex_ready    : datapath accepts the instruction on offer
//   rom_en      : ROM read strobe
//   rom_addr    : ROM address, mirrors ins_address
//   ir_valid    : opcode/operand are on offer to the datapath
//   opcode      : latched instruction opcode
//   operand     : latched instruction operand
//   pc_inc      : one-cycle PC increment pulse
//   pc_load     : one-cycle PC load pulse
//   pc_target   : PC load value, mirrors operand
//   finish      : execution halted
//   ins_count   : retired-instruction count, saturating
// The master modport is the fetch unit; slave is the environment side.
interface ins_fetch_if;
    logic        start;
    logic [7:0]  ins_address;
    logic [15:0] rom_data;
    logic        z_flag;
    logic        ex_ready;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic        ir_valid;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        finish;
    logic [15:0] ins_count;

    modport master (
        input  start, ins_address, rom_data, z_flag, ex_ready,
        output rom_en, rom_addr, ir_valid, opcode, operand,
               pc_inc, pc_load, pc_target, finish, ins_count
    );

    modport slave (
        output start, ins_address, rom_data, z_flag, ex_ready,
        input  rom_en, rom_addr, ir_valid, opcode, operand,
               pc_inc, pc_load, pc_target, finish, ins_count
    );
endinterface

// File: rtl/ins_fetch.sv
// ins_fetch
// Instruction fetch and sequencing unit. Reads the word at the current PC,
// latches it, resolves jumps/NOP/END locally, hands every other opcode to
// the datapath over a valid/ready handshake and then issues exactly one
// PC increment or load pulse. Minimum CPI is 4 with an always-ready datapath.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; returns to IDLE with outputs cleared
//   bus   : ins_fetch_if.master carrying the PC, ROM and datapath signals
// Optional build macro ILLEGAL_OP_TRAP_EN: when defined, opcodes 8'hF3..8'hFE
// halt the unit without retiring; when undefined they are forwarded as
// ordinary instructions.
module ins_fetch #(
    parameter logic [7:0] END_OP   = 8'hFF,
    parameter logic [7:0] JMP_OP   = 8'hF0,
    parameter logic [7:0] JMPZ_OP  = 8'hF1,
    parameter logic [7:0] JMPNZ_OP = 8'hF2,
    parameter logic [7:0] NOP_OP   = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    ins_fetch_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, DECODE, UPDATE, HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  opcode_q;
    logic [7:0]  operand_q;
    logic        load_sel;
    logic        load_sel_next;
    logic [15:0] count_q;
    logic        count_en;
    logic        ir_valid;

    logic        is_end;
    logic        is_jmp;
    logic        is_jmpz;
    logic        is_jmpnz;
    logic        is_nop;
    logic        is_illegal;

    // Opcode classification of the latched instruction word.
    assign is_end   = (opcode_q == END_OP);
    assign is_jmp   = (opcode_q == JMP_OP);
    assign is_jmpz  = (opcode_q == JMPZ_OP);
    assign is_jmpnz = (opcode_q == JMPNZ_OP);
    assign is_nop   = (opcode_q == NOP_OP);
`ifdef ILLEGAL_OP_TRAP_EN
    assign is_illegal = (opcode_q >= 8'hF3) && (opcode_q <= 8'hFE);
`else
    assign is_illegal = 1'b0;
`endif

    // Next-state logic. Control opcodes are checked before the illegal
    // range so an overridden END/JMP value inside that range still works.
    // load_sel is decided in DECODE and consumed one cycle later in UPDATE.
    always_comb begin
        state_next    = state;
        load_sel_next = load_sel;
        count_en      = 1'b0;
        ir_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH;
                end
            end
            FETCH: state_next = LATCH;
            LATCH: state_next = DECODE;
            DECODE: begin
                if (is_end) begin
                    state_next = HALT;
                    count_en   = 1'b1;
                end else if (is_jmp) begin
                    state_next    = UPDATE;
                    load_sel_next = 1'b1;
                end else if (is_jmpz) begin
                    state_next    = UPDATE;
                    load_sel_next = bus.z_flag;
                end else if (is_jmpnz) begin
                    state_next    = UPDATE;
                    load_sel_next = ~bus.z_flag;
                end else if (is_nop) begin
                    state_next    = UPDATE;
                    load_sel_next = 1'b0;
                end else if (is_illegal) begin
                    state_next = HALT;
                end else begin
                    ir_valid = 1'b1;
                    if (bus.ex_ready) begin
                        state_next    = UPDATE;
                        load_sel_next = 1'b0;
                    end
                end
            end
            UPDATE: begin
                count_en   = 1'b1;
                state_next = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // State, instruction register and saturating retire counter.
    // The instruction word is captured on the edge that ends LATCH, which is
    // when the one-cycle-latency ROM presents the fetched word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            load_sel  <= 1'b0;
            count_q   <= 16'h0000;
        end else begin
            state    <= state_next;
            load_sel <= load_sel_next;
            if (state == LATCH) begin
                opcode_q  <= bus.rom_data[15:8];
                operand_q <= bus.rom_data[7:0];
            end
            if (count_en && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'h0001;
            end
        end
    end

    // Outputs decode directly from state so every pulse is exactly one cycle.
    assign bus.rom_en    = (state == FETCH);
    assign bus.rom_addr  = bus.ins_address;
    assign bus.ir_valid  = ir_valid;
    assign bus.opcode    = opcode_q;
    assign bus.operand   = operand_q;
    assign bus.pc_inc    = (state == UPDATE) && !load_sel;
    assign bus.pc_load   = (state == UPDATE) && load_sel;
    assign bus.pc_target = operand_q;
    assign bus.finish    = (state == HALT);
    assign bus.ins_count = count_q;

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch and sequencing unit for the downsampling processor. It sits between the program counter, the instruction ROM and the execute datapath. It reads the 16-bit instruction word at the current PC address, latches it and resolves branch and halt opcodes locally. Ordinary instructions go to the datapath through a valid/ready handshake, and the block then issues exactly one PC increment or load pulse per instruction. With an always-ready datapath the minimum rate is CPI = 4.

## Interface
Parameters:
- `END_OP`, default 8'hFF: halt opcode.
- `JMP_OP`, default 8'hF0: unconditional jump.
- `JMPZ_OP`, default 8'hF1: jump if `z_flag` = 1.
- `JMPNZ_OP`, default 8'hF2: jump if `z_flag` = 0.
- `NOP_OP`, default 8'h00: no operation, retired without handshake.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin execution; sampled only in IDLE.
- `ins_address`, in, 8: current PC value.
- `rom_data`, in, 16: ROM word; {opcode[15:8], operand[7:0]}; valid the cycle after `rom_en`.
- `z_flag`, in, 1: zero flag from the datapath.
- `ex_ready`, in, 1: datapath accepts the instruction.
- `rom_en`, out, 1: ROM read strobe.
- `rom_addr`, out, 8: ROM address; equals `ins_address`.
- `ir_valid`, out, 1: `opcode`/`operand` are valid for the datapath.
- `opcode`, out, 8: latched instruction opcode.
- `operand`, out, 8: latched instruction operand.
- `pc_inc`, out, 1: one-cycle PC increment pulse.
- `pc_load`, out, 1: one-cycle PC load pulse.
- `pc_target`, out, 8: load value for the PC C_bus; equals `operand`.
- `finish`, out, 1: execution halted.
- `ins_count`, out, 16: retired-instruction count; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, LATCH, DECODE, UPDATE, HALT.
- IDLE → FETCH when `start` = 1.
- FETCH: `rom_en` = 1 → LATCH.
- LATCH: on this clock edge `{opcode, operand}` ← `rom_data` → DECODE.
- DECODE, resolved by opcode:
  - `END_OP`: → HALT. `ir_valid` stays 0, no PC pulse, `ins_count` += 1.
  - `JMP_OP`: → UPDATE with load selected.
  - `JMPZ_OP` / `JMPNZ_OP`: evaluate `z_flag` in DECODE. Taken → UPDATE with load; not taken → UPDATE with increment.
  - `NOP_OP`: → UPDATE with increment, no handshake.
  - Any other opcode: `ir_valid` = 1, held until the cycle where `ex_ready` = 1. That cycle is the transfer; then → UPDATE with increment.
- UPDATE: exactly one of `pc_load` / `pc_inc` = 1 for one cycle; `ins_count` += 1 (saturating) → FETCH.
- HALT: `finish` = 1. `start` is ignored; only `reset` exits.
- `start` outside IDLE is ignored.
- Reset, including mid-operation, returns to IDLE. All outputs read 0: `rom_en`, `ir_valid`, `opcode`, `operand`, `pc_inc`, `pc_load`, `pc_target`, `finish`, `ins_count`. `rom_addr` follows `ins_address`.
- `reset` dominates `start` in the same cycle.
- `opcode`/`operand` are stable from LATCH until the next LATCH.

## Timing
- `start` sampled at edge 0 → FETCH in cycle 1, LATCH in cycle 2, DECODE in cycle 3, UPDATE in cycle 4, next FETCH in cycle 5.
- CPI = 4 when `ex_ready` = 1 in DECODE; each extra DECODE cycle adds 1.
- ROM read latency is 1 cycle; data is captured at the end of LATCH.
- PC updates at the edge that ends UPDATE, so the next FETCH uses the new `ins_address`.
- `z_flag` for a conditional jump is sampled in DECODE only.
- `finish` rises in the cycle after END's DECODE.

## Configuration
- Macro: `ILLEGAL_OP_TRAP_EN`.
- Defined: opcodes 8'hF3–8'hFE are illegal. DECODE goes to HALT with no handshake and no PC pulse; `finish` = 1; `ins_count` is unchanged.
- Undefined: those opcodes are treated as ordinary instructions, forwarded with `ir_valid` and followed by `pc_inc`.

## Test plan
- Straight line: ROM[0]=16'h1203, ROM[1]=16'hFF00, `ex_ready`=1, start at cycle 0. Expected: `ir_valid` in cycle 3 with `opcode`=8'h12 and `operand`=8'h03; `pc_inc` in cycle 4; `finish`=1 from cycle 8; `ins_count`=2.
- Stall: `ex_ready` held 0 for 3 cycles in DECODE. Expected: `ir_valid`, `opcode` and `operand` stable throughout; `pc_inc` 4 cycles after DECODE entry.
- Branch: `z_flag`=1 with ROM word 16'hF140. Expected: `pc_load`=1 with `pc_target`=8'h40 and no `ir_valid`. Repeat with `z_flag`=0: `pc_inc` instead. Repeat with 16'hF240 and `z_flag`=0: `pc_load`.
- Reset mid-DECODE with `ir_valid`=1: next cycle all outputs 0 and state IDLE. A subsequent `start` refetches at the current `ins_address`.
- Illegal 16'hF500: with the macro, `finish`=1 and no `ir_valid`. Without it, `ir_valid`=1 with `opcode`=8'hF5, then `pc_inc`.
- Saturation: preload `ins_count` to 16'hFFFE and run three NOPs. Expected: the count stops at 16'hFFFF.
